// File: rtl/irq_pending_ctrl_pkg.sv
// Shared types and constants for the interrupt pending controller.
// State encodings, source indices and a one-hot helper.
package irq_pending_ctrl_pkg;

  localparam int NSRC = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] SRC_A = 2'd0;
  localparam logic [1:0] SRC_B = 2'd1;
  localparam logic [1:0] SRC_C = 2'd2;
  localparam logic [1:0] SRC_D = 2'd3;

  function automatic logic [NSRC-1:0] src_onehot(input logic [1:0] id);
    src_onehot     = '0;
    src_onehot[id] = 1'b1;
  endfunction

endpackage

// File: rtl/irq_pending_ctrl_prio.sv
// Combinational 4->2 highest-index priority encoder (D > C > B > A).
// Must match the downstream selector's encoder exactly.
module irq_prio_enc4
  import irq_pending_ctrl_pkg::*;
(
  input  logic [NSRC-1:0] vec,
  output logic [1:0]      idx,
  output logic            valid
);

  always_comb begin
    idx   = SRC_A;
    valid = |vec;
    if (vec[SRC_D])      idx = SRC_D;
    else if (vec[SRC_C]) idx = SRC_C;
    else if (vec[SRC_B]) idx = SRC_B;
  end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Pending-flag capture, enable masking and ack/eoi handshake in front of
// the 4-source interrupt selector.
module irq_pending_ctrl
  import irq_pending_ctrl_pkg::*;
#(
  parameter logic [NSRC-1:0] EDGE_MODE = 4'b1111,
  parameter logic [NSRC-1:0] RESET_IE  = 4'b0000
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [NSRC-1:0] req,
  input  logic            ie_wr,
  input  logic [NSRC-1:0] ie_in,
  input  logic            gen_wr,
  input  logic            gen_in,
  input  logic            ack,
  input  logic            eoi,
  output logic            sa,
  output logic            sb,
  output logic            sc,
  output logic            sd,
  output logic            m,
  output logic            irq,
  output logic [1:0]      active_id,
  output logic            in_service,
  output logic [NSRC-1:0] pending
);

  logic [NSRC-1:0] pending_reg;
  logic [NSRC-1:0] prev_req_reg;
  logic [NSRC-1:0] ie_reg;
  logic            gen_reg;
  state_t          state_reg;
  logic [1:0]      active_id_reg;
  logic            irq_reg;
  logic            m_reg;
  logic            in_service_reg;

  logic [NSRC-1:0] masked;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] clr;
  logic [NSRC-1:0] pending_next;
  logic [NSRC-1:0] sel;
  logic [1:0]      enc_idx;
  logic            enc_valid;
  logic            take_ack;

  assign masked = pending_reg & ie_reg;
  assign rise   = req & ~prev_req_reg;

  irq_prio_enc4 u_enc (
    .vec   (masked),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  // An ack only counts when the FSM actually moves ARMED -> SERVICE.
  assign take_ack = (state_reg == ST_ARMED) && gen_reg && enc_valid && ack;
  assign clr      = take_ack ? src_onehot(enc_idx) : '0;

  // Edge sources: a new rising edge beats a same-cycle clear.
  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_pend
      assign pending_next[gi] = EDGE_MODE[gi]
                                ? (rise[gi] | (pending_reg[gi] & ~clr[gi]))
                                : req[gi];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_reg  <= '0;
      prev_req_reg <= '0;
      ie_reg       <= RESET_IE;
      gen_reg      <= 1'b0;
    end else begin
      pending_reg  <= pending_next;
      prev_req_reg <= req;
      if (ie_wr)  ie_reg  <= ie_in;
      if (gen_wr) gen_reg <= gen_in;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      active_id_reg  <= SRC_A;
      irq_reg        <= 1'b0;
      m_reg          <= 1'b0;
      in_service_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (gen_reg && enc_valid) begin
            state_reg <= ST_ARMED;
            irq_reg   <= 1'b1;
            m_reg     <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (!gen_reg || !enc_valid) begin
            state_reg <= ST_IDLE;
            irq_reg   <= 1'b0;
            m_reg     <= 1'b0;
          end else if (ack) begin
            state_reg      <= ST_SERVICE;
            irq_reg        <= 1'b0;
            in_service_reg <= 1'b1;
            active_id_reg  <= enc_idx;
          end
        end
        ST_SERVICE: begin
          if (eoi) begin
            state_reg      <= ST_IDLE;
            m_reg          <= 1'b0;
            in_service_reg <= 1'b0;
          end
        end
        default: begin
          state_reg      <= ST_IDLE;
          irq_reg        <= 1'b0;
          m_reg          <= 1'b0;
          in_service_reg <= 1'b0;
        end
      endcase
    end
  end

  // While servicing, the selector keeps seeing only the serviced source.
  assign sel = in_service_reg ? src_onehot(active_id_reg) : masked;

  assign sa         = sel[SRC_A];
  assign sb         = sel[SRC_B];
  assign sc         = sel[SRC_C];
  assign sd         = sel[SRC_D];
  assign m          = m_reg;
  assign irq        = irq_reg;
  assign active_id  = active_id_reg;
  assign in_service = in_service_reg;
  assign pending    = pending_reg;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Randomized + directed bench for irq_pending_ctrl against a behavioural
// model; source A is level-triggered, B..D edge-triggered.
module tb_irq_pending_ctrl;

  localparam logic [3:0] EDGE_MODE = 4'b1110;
  localparam logic [3:0] RESET_IE  = 4'b0101;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] req = '0;
  logic       ie_wr = 1'b0;
  logic [3:0] ie_in = '0;
  logic       gen_wr = 1'b0;
  logic       gen_in = 1'b0;
  logic       ack = 1'b0;
  logic       eoi = 1'b0;
  logic       sa, sb, sc, sd, m, irq, in_service;
  logic [1:0] active_id;
  logic [3:0] pending;

  logic [3:0] enc_vec = '0;
  logic [1:0] enc_idx;
  logic       enc_valid;

  irq_pending_ctrl #(
    .EDGE_MODE (EDGE_MODE),
    .RESET_IE  (RESET_IE)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (req),
    .ie_wr      (ie_wr),
    .ie_in      (ie_in),
    .gen_wr     (gen_wr),
    .gen_in     (gen_in),
    .ack        (ack),
    .eoi        (eoi),
    .sa         (sa),
    .sb         (sb),
    .sc         (sc),
    .sd         (sd),
    .m          (m),
    .irq        (irq),
    .active_id  (active_id),
    .in_service (in_service),
    .pending    (pending)
  );

  irq_prio_enc4 u_enc_chk (
    .vec   (enc_vec),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Behavioural model: pending bits, enables, and "waiting for ack" / "serving" flags.
  bit pend_m [4];
  bit prev_m [4];
  bit ie_m   [4];
  bit gen_m;
  bit waiting_ack;
  bit serving;
  int serv_id;

  task automatic reset_model();
    for (int i = 0; i < 4; i++) begin
      pend_m[i] = 0;
      prev_m[i] = 0;
      ie_m[i]   = RESET_IE[i];
    end
    gen_m       = 0;
    waiting_ack = 0;
    serving     = 0;
    serv_id     = 0;
  endtask

  function automatic int top_src();
    for (int i = 3; i >= 0; i--)
      if (pend_m[i] && ie_m[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    int top;
    bit granted;
    bit n_pend [4];
    top = top_src();
    granted = waiting_ack && gen_m && (top >= 0) && ack;
    for (int i = 0; i < 4; i++) begin
      if (EDGE_MODE[i]) begin
        if (req[i] && !prev_m[i])      n_pend[i] = 1;
        else if (granted && top == i)  n_pend[i] = 0;
        else                           n_pend[i] = pend_m[i];
      end else begin
        n_pend[i] = req[i];
      end
    end
    if (serving) begin
      if (eoi) serving = 0;
    end else if (waiting_ack) begin
      if (!gen_m || top < 0) waiting_ack = 0;
      else if (ack) begin
        waiting_ack = 0;
        serving     = 1;
        serv_id     = top;
      end
    end else if (gen_m && top >= 0) begin
      waiting_ack = 1;
    end
    for (int i = 0; i < 4; i++) begin
      pend_m[i] = n_pend[i];
      prev_m[i] = req[i];
      if (ie_wr) ie_m[i] = ie_in[i];
    end
    if (gen_wr) gen_m = gen_in;
  endtask

  function automatic logic [12:0] expected_outs();
    logic [3:0] pv;
    logic [3:0] sel;
    logic [3:0] one;
    one = 4'b0001;
    for (int i = 0; i < 4; i++) pv[i] = pend_m[i];
    sel = '0;
    if (serving) sel = one << serv_id;
    else for (int i = 0; i < 4; i++) sel[i] = pend_m[i] & ie_m[i];
    return {waiting_ack, waiting_ack | serving, serving, 2'(serv_id), pv, sel};
  endfunction

  function automatic logic [12:0] observed_outs();
    return {irq, m, in_service, active_id, pending, sd, sc, sb, sa};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    check_val("cycle_outs", 32'(observed_outs()), 32'(expected_outs()));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_idx;
    reset_model();

    // Encoder, exhaustively
    for (int v = 0; v < 16; v++) begin
      enc_vec = 4'(v);
      #1;
      exp_idx = 0;
      for (int i = 0; i < 4; i++) if (v & (1 << i)) exp_idx = i;
      check_val("enc_idx", 32'(enc_idx), 32'(exp_idx));
      check_val("enc_valid", 32'(enc_valid), 32'(v != 0));
    end
    $display("encoder: 16 patterns checked");

    repeat (2) @(posedge clock);
    #1;
    check_val("reset_outs", 32'(observed_outs()), 32'd0);
    reset_n = 1'b1;
    $display("reset released");

    // Enable everything, pulse B
    ie_wr = 1; ie_in = 4'b1111; gen_wr = 1; gen_in = 1;
    tick();
    ie_wr = 0; gen_wr = 0;
    req = 4'b0010;
    tick();
    req = 4'b0000;
    check_val("b_pend", 32'(pending), 32'h2);
    check_val("b_irq_early", 32'(irq), 32'd0);
    tick();
    check_val("b_irq", 32'(irq), 32'd1);
    check_val("b_lines", 32'({sd, sc, sb, sa}), 32'h2);
    check_val("b_m", 32'(m), 32'd1);
    $display("txn: req B -> irq=%0d sb=%0d", irq, sb);
    ack = 1; tick(); ack = 0;
    eoi = 1; tick(); eoi = 0;

    // Priority: B and C together
    req = 4'b0110; tick();
    req = 4'b0000; tick();
    check_val("prio_irq", 32'(irq), 32'd1);
    ack = 1; tick(); ack = 0;
    check_val("prio_id", 32'(active_id), 32'd2);
    check_val("prio_pend", 32'(pending), 32'h2);
    check_val("prio_lines", 32'({sd, sc, sb, sa}), 32'h4);
    check_val("prio_insvc", 32'(in_service), 32'd1);
    $display("txn: ack -> active_id=%0d pending=%b", active_id, pending);
    eoi = 1; tick(); eoi = 0;
    check_val("eoi_insvc", 32'(in_service), 32'd0);
    check_val("eoi_id_hold", 32'(active_id), 32'd2);
    tick();
    check_val("b2b_irq", 32'(irq), 32'd1);
    ack = 1; tick(); ack = 0;
    check_val("b2b_id", 32'(active_id), 32'd1);
    $display("txn: back-to-back ack -> active_id=%0d", active_id);
    eoi = 1; tick(); eoi = 0;

    // Masking D
    ie_wr = 1; ie_in = 4'b0111; tick(); ie_wr = 0;
    req = 4'b1000; tick();
    req = 4'b0000; tick();
    check_val("mask_pend", 32'(pending), 32'h8);
    check_val("mask_irq", 32'(irq), 32'd0);
    ie_wr = 1; ie_in = 4'b1111; tick(); ie_wr = 0;
    check_val("unmask_irq_early", 32'(irq), 32'd0);
    tick();
    check_val("unmask_irq", 32'(irq), 32'd1);
    check_val("unmask_sd", 32'(sd), 32'd1);
    $display("txn: unmask D -> irq=%0d sd=%0d", irq, sd);
    ack = 1; tick(); ack = 0;
    eoi = 1; tick(); eoi = 0;

    // Level source A
    req = 4'b0001; tick(); tick();
    check_val("lvl_irq", 32'(irq), 32'd1);
    ack = 1; tick(); ack = 0;
    check_val("lvl_pend_kept", 32'(pending), 32'h1);
    eoi = 1; tick(); eoi = 0;
    tick();
    check_val("lvl_reassert", 32'(irq), 32'd1);
    req = 4'b0000; tick(); tick();
    check_val("lvl_drop_irq", 32'(irq), 32'd0);
    check_val("lvl_drop_m", 32'(m), 32'd0);
    $display("txn: level A dropped -> irq=%0d", irq);

    // Same-cycle edge and ack on D, then ack+eoi together
    req = 4'b1000; tick();
    req = 4'b0000; tick();
    req = 4'b1000; ack = 1; tick(); ack = 0; req = 4'b0000;
    check_val("setwin_pend", 32'(pending), 32'h8);
    check_val("setwin_insvc", 32'(in_service), 32'd1);
    eoi = 1; tick(); eoi = 0;
    tick();
    ack = 1; eoi = 1; tick(); ack = 0; eoi = 0;
    check_val("ackeoi_insvc", 32'(in_service), 32'd1);
    check_val("ackeoi_irq", 32'(irq), 32'd0);
    $display("txn: ack+eoi together -> in_service=%0d", in_service);

    // Async reset in service with pending B and D
    req = 4'b1010; tick(); req = 4'b0000;
    check_val("pre_rst_pend", 32'(pending), 32'ha);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("async_rst_outs", 32'(observed_outs()), 32'd0);
    reset_model();
    #1;
    reset_n = 1'b1;
    $display("txn: async reset mid-service");
    // Only RESET_IE sources can fire after reset
    req = 4'b0100; gen_wr = 1; gen_in = 1; tick();
    req = 4'b0000; gen_wr = 0; tick();
    check_val("rstie_irq", 32'(irq), 32'd1);
    check_val("rstie_sc", 32'(sc), 32'd1);
    ack = 1; tick(); ack = 0;
    eoi = 1; tick(); eoi = 0;

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      req    = req ^ 4'($urandom & $urandom);
      ack    = ($urandom % 4) == 0;
      eoi    = ($urandom % 4) == 0;
      ie_wr  = ($urandom % 16) == 0;
      ie_in  = 4'($urandom);
      gen_wr = ($urandom % 16) == 0;
      gen_in = ($urandom % 4) != 0;
      tick();
      if (c % 500 == 499) $display("random: %0d cycles done", c + 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
